// File: rtl/inc_scheduler_pkg.sv
// Shared types and defaults for the increment scheduler and its clients.
// The tick defaults are also used by the prescaler configuration.
package inc_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } state_e;

  localparam int DEFAULT_DLY_TICKS = 32'd8;
  localparam int DEFAULT_REP_TICKS = 32'd2;

  // Index following idx in a ring of n entries.
  function automatic int wrap_next(input int idx, input int n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/inc_scheduler_rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after ptr,
// wrapping to the lowest set bit below ptr when none is found at or above it.
module rr_pick #(
  parameter int DIGITS = 2,
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic [DIGITS-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [DIGITS-1:0] grant,
  output logic [PW-1:0]     idx
);

  localparam logic [DIGITS-1:0] ONE_HOT_0 = DIGITS'(1);

  logic          hi_found_s, lo_found_s;
  logic [PW-1:0] hi_idx_s, lo_idx_s;

  // Descending scan so the lowest matching index in each half is kept.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = {PW{1'b0}};
    lo_idx_s   = {PW{1'b0}};
    for (int j = DIGITS - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (PW'(j) >= ptr) begin
          hi_found_s = 1'b1;
          hi_idx_s   = PW'(j);
        end else begin
          lo_found_s = 1'b1;
          lo_idx_s   = PW'(j);
        end
      end else begin
        hi_found_s = hi_found_s;
      end
    end
  end

  // Winner selection and one-hot encoding.
  always_comb begin
    idx = hi_found_s ? hi_idx_s : lo_idx_s;
    if (hi_found_s || lo_found_s) begin
      grant = ONE_HOT_0 << idx;
    end else begin
      grant = {DIGITS{1'b0}};
    end
  end

endmodule

// File: rtl/inc_scheduler.sv
// Round-robin increment scheduler with press-and-hold auto-repeat: turns held
// button levels and prescaler ticks into one-hot, one-cycle increment pulses.
module inc_scheduler
  import inc_scheduler_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int DLY_TICKS = DEFAULT_DLY_TICKS,
  parameter int REP_TICKS = DEFAULT_REP_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] req,
  input  logic              tick,
  output logic [DIGITS-1:0] inc,
  output logic              repeating,
  output logic              busy
);

  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HW = (DLY_TICKS > 1) ? $clog2(DLY_TICKS) : 1;
  localparam int RW = (REP_TICKS > 1) ? $clog2(REP_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(DLY_TICKS - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_TICKS - 1);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  state_e            state_r, state_s;
  logic [DIGITS-1:0] req_q_r, inc_r, inc_s, grant_s;
  logic [PW-1:0]     ptr_r, ptr_s, win_idx_s;
  logic [HW-1:0]     hold_cnt_r, hold_cnt_s;
  logic [RW-1:0]     rep_cnt_r, rep_cnt_s;
  logic              repeating_r, busy_r;
  logic              any_req_s, new_press_s, issue_s;

  assign any_req_s   = |req;
  assign new_press_s = |(req & ~req_q_r);

  rr_pick #(.DIGITS(DIGITS)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (win_idx_s)
  );

  // Next-state, counter and issue decisions; a full release overrides everything.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    rep_cnt_s  = rep_cnt_r;
    issue_s    = 1'b0;
    if (!any_req_s) begin
      state_s    = IDLE;
      hold_cnt_s = {HW{1'b0}};
      rep_cnt_s  = {RW{1'b0}};
    end else begin
      case (state_r)
        IDLE: state_s = ARM;
        ARM: begin
          if (tick) begin
            issue_s    = 1'b1;
            hold_cnt_s = {HW{1'b0}};
            state_s    = HOLD;
          end else begin
            state_s = ARM;
          end
        end
        HOLD: begin
          if (new_press_s) begin
            state_s = ARM;
          end else if (tick) begin
            if (hold_cnt_r == HOLD_LAST) begin
              state_s   = REPEAT;
              rep_cnt_s = {RW{1'b0}};
            end else begin
              hold_cnt_s = hold_cnt_r + HOLD_ONE;
            end
          end else begin
            state_s = HOLD;
          end
        end
        REPEAT: begin
          if (new_press_s) begin
            state_s = ARM;
          end else if (tick) begin
            if (rep_cnt_r == REP_LAST) begin
              issue_s   = 1'b1;
              rep_cnt_s = {RW{1'b0}};
            end else begin
              rep_cnt_s = rep_cnt_r + REP_ONE;
            end
          end else begin
            state_s = REPEAT;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Issue pulse and pointer advance past the winner.
  always_comb begin
    if (issue_s) begin
      inc_s = grant_s;
      ptr_s = PW'(wrap_next(int'(win_idx_s), DIGITS));
    end else begin
      inc_s = {DIGITS{1'b0}};
      ptr_s = ptr_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_q_r     <= {DIGITS{1'b0}};
      ptr_r       <= {PW{1'b0}};
      hold_cnt_r  <= {HW{1'b0}};
      rep_cnt_r   <= {RW{1'b0}};
      inc_r       <= {DIGITS{1'b0}};
      repeating_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_q_r     <= req;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      rep_cnt_r   <= rep_cnt_s;
      inc_r       <= inc_s;
      repeating_r <= (state_s == REPEAT);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign inc       = inc_r;
  assign repeating = repeating_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_inc_scheduler.sv
// Directed bench for inc_scheduler: DIGITS=2, DLY_TICKS=4, REP_TICKS=2,
// one tick every 4 clocks.
module tb_inc_scheduler;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       tick;
  logic [1:0] inc;
  logic       repeating;
  logic       busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  inc_scheduler #(.DIGITS(2), .DLY_TICKS(4), .REP_TICKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .tick      (tick),
    .inc       (inc),
    .repeating (repeating),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic [1:0] r);
    tick  = 1'b0;
    rst_n = 1'b0;
    req   = r;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    tick = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One tick period: first = inc right after the tick edge, other = OR of the rest.
  task automatic period(output logic [1:0] first, output logic [1:0] other, output logic rep);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    first = inc;
    other = 2'b00;
    repeat (3) begin
      @(posedge clk);
      #1;
      other |= inc;
    end
    rep = repeating;
  endtask

  task automatic test_reset();
    tick  = 1'b0;
    rst_n = 1'b0;
    req   = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({inc, repeating, busy} !== 4'b0000) $display("FAIL reset_outputs: got %b expected 0000", {inc, repeating, busy});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_tap();
    logic [1:0] f, o;
    logic r;
    do_reset(2'b00);
    req = 2'b01;
    idle_cycle();
    period(f, o, r);
    chk_cnt++;
    if (f !== 2'b01) $display("FAIL tap_inc: got %b expected 01", f); else pass_cnt++;
    chk_cnt++;
    if (o !== 2'b00) $display("FAIL tap_extra: got %b expected 00", o); else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL tap_busy_held: got %b expected 1", busy); else pass_cnt++;
    req = 2'b00;
    idle_cycle();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL tap_busy_release: got %b expected 0", busy); else pass_cnt++;
    // Pointer now at 1: both held, digit 1 wins.
    req = 2'b11;
    idle_cycle();
    period(f, o, r);
    chk_cnt++;
    if (f !== 2'b10) $display("FAIL tap_ptr: got %b expected 10", f); else pass_cnt++;
    req = 2'b00;
    idle_cycle();
  endtask

  task automatic test_hold();
    logic [1:0] f, o;
    logic r;
    logic [1:0] exp_f [1:12];
    for (int k = 1; k <= 12; k++) exp_f[k] = 2'b00;
    exp_f[1] = 2'b01; exp_f[7] = 2'b01; exp_f[9] = 2'b01; exp_f[11] = 2'b01;
    do_reset(2'b00);
    req = 2'b01;
    idle_cycle();
    for (int k = 1; k <= 12; k++) begin
      period(f, o, r);
      chk_cnt++;
      if (f !== exp_f[k] || o !== 2'b00) $display("FAIL hold_tick%0d: got %b/%b expected %b/00", k, f, o, exp_f[k]);
      else pass_cnt++;
      chk_cnt++;
      if (r !== (k >= 5)) $display("FAIL hold_rep%0d: got %b expected %b", k, r, (k >= 5));
      else pass_cnt++;
    end
    req = 2'b00;
    idle_cycle();
  endtask

  task automatic test_dual_hold();
    logic [1:0] f, o;
    logic r;
    logic [1:0] exp_f [1:11];
    for (int k = 1; k <= 11; k++) exp_f[k] = 2'b00;
    exp_f[1] = 2'b01; exp_f[7] = 2'b10; exp_f[9] = 2'b01; exp_f[11] = 2'b10;
    do_reset(2'b11);
    for (int k = 1; k <= 11; k++) begin
      period(f, o, r);
      chk_cnt++;
      if (f !== exp_f[k] || o !== 2'b00) $display("FAIL dual_tick%0d: got %b/%b expected %b/00", k, f, o, exp_f[k]);
      else pass_cnt++;
    end
    req = 2'b00;
    idle_cycle();
  endtask

  task automatic test_second_press();
    logic [1:0] f, o;
    logic r;
    logic [1:0] exp_f [1:9];
    for (int k = 1; k <= 9; k++) exp_f[k] = 2'b00;
    exp_f[1] = 2'b01; exp_f[3] = 2'b10; exp_f[9] = 2'b01;
    do_reset(2'b00);
    req = 2'b01;
    idle_cycle();
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin
        req = 2'b11;
        idle_cycle();
      end
      period(f, o, r);
      chk_cnt++;
      if (f !== exp_f[k] || o !== 2'b00) $display("FAIL press2_tick%0d: got %b/%b expected %b/00", k, f, o, exp_f[k]);
      else pass_cnt++;
      if (k == 6 || k == 7) begin
        chk_cnt++;
        if (r !== (k == 7)) $display("FAIL press2_rep%0d: got %b expected %b", k, r, (k == 7));
        else pass_cnt++;
      end
    end
    req = 2'b00;
    idle_cycle();
  endtask

  task automatic test_coincident_release();
    do_reset(2'b00);
    req = 2'b01;
    idle_cycle();
    req  = 2'b00;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk_cnt++;
    if ({inc, busy} !== 3'b000) $display("FAIL release_tick: got %b expected 000", {inc, busy}); else pass_cnt++;
    idle_cycle();
    chk_cnt++;
    if ({inc, busy, repeating} !== 4'b0000) $display("FAIL release_after: got %b expected 0000", {inc, busy, repeating});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [1:0] f, o;
    logic r;
    do_reset(2'b00);
    req = 2'b01;
    idle_cycle();
    for (int k = 1; k <= 6; k++) period(f, o, r);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk_cnt++;
    if ({inc, repeating, busy} !== 4'b0111) $display("FAIL areset_pre: got %b expected 0111", {inc, repeating, busy});
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    req   = 2'b11;
    #1;
    chk_cnt++;
    if ({inc, repeating, busy} !== 4'b0000) $display("FAIL areset_drop: got %b expected 0000", {inc, repeating, busy});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    period(f, o, r);
    chk_cnt++;
    if (f !== 2'b01) $display("FAIL areset_ptr: got %b expected 01", f); else pass_cnt++;
    req = 2'b00;
    idle_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    tick  = 1'b0;
    test_reset();
    test_tap();
    test_hold();
    test_dual_hold();
    test_second_press();
    test_coincident_release();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
